frame_renderer: RTL

FRAME_RENDERER -- requirements
Module: frame_renderer

---
 rtl/frame_renderer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/frame_renderer.sv
// frame_renderer
//   Renders one 160x120 frame to a VGA adapter, one pixel per clock in raster
//   order, after a start request. Two 4x4 ship boxes (user, enemy) and a
//   bullet bitmap are composited with fixed priority: user > enemy > bullet
//   > background.
//
//   Optional feature: define HEALTH_BAR_EN to overlay a health bar on rows
//   0..1, columns 0..ship_health*8-1, drawn above everything else.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   start        in   frame request, sampled only while idle
//   user_x/y     in   user ship top-left corner
//   enemy_x/y    in   enemy ship top-left corner
//   grid         in   bullet bitmap, bit (y*160+x); sampled live per pixel
//   ship_health  in   health 0..15 (used only with HEALTH_BAR_EN)
//   x, y         out  pixel coordinate
//   colour       out  pixel colour {R,G,B}
//   plot         out  pixel write enable
//   done         out  one-cycle pulse after the final pixel of a frame
module frame_renderer (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    user_x,
  input  logic [6:0]    user_y,
  input  logic [7:0]    enemy_x,
  input  logic [6:0]    enemy_y,
  input  logic [19199:0] grid,
  input  logic [3:0]    ship_health,
  output logic [7:0]    x,
  output logic [6:0]    y,
  output logic [2:0]    colour,
  output logic          plot,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DONE
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  col, col_nx;
  logic [6:0]  row, row_nx;
  logic [7:0]  ux_q, ux_nx, ex_q, ex_nx;
  logic [6:0]  uy_q, uy_nx, ey_q, ey_nx;
  logic [7:0]  x_nx;
  logic [6:0]  y_nx;
  logic [2:0]  colour_nx;
  logic        plot_nx, done_nx;
  logic [2:0]  pix_colour;
  logic [14:0] pix_idx;
  logic [8:0]  col9, row9;
  logic        user_hit, enemy_hit;

`ifdef HEALTH_BAR_EN
  logic [3:0]  hp_q, hp_nx;
  logic        bar_hit;
`else
  logic        hp_unused;
  assign hp_unused = ^ship_health;
`endif

  // Box tests are done in 9 bits so sx+3 past 159/119 clips instead of wrapping.
  assign col9      = {1'b0, col};
  assign row9      = {2'b00, row};
  assign user_hit  = (col9 >= {1'b0, ux_q}) && (col9 <= ({1'b0, ux_q} + 9'd3)) &&
                     (row9 >= {2'b00, uy_q}) && (row9 <= ({2'b00, uy_q} + 9'd3));
  assign enemy_hit = (col9 >= {1'b0, ex_q}) && (col9 <= ({1'b0, ex_q} + 9'd3)) &&
                     (row9 >= {2'b00, ey_q}) && (row9 <= ({2'b00, ey_q} + 9'd3));
  assign pix_idx   = ({8'd0, row} * 15'd160) + {7'd0, col};

`ifdef HEALTH_BAR_EN
  assign bar_hit = (row < 7'd2) && (col9 < {2'b00, hp_q, 3'b000});
`endif

  always_comb begin
    pix_colour = 3'b000;
    if (user_hit)
      pix_colour = 3'b010;
    else if (enemy_hit)
      pix_colour = 3'b100;
    else if (grid[pix_idx])
      pix_colour = 3'b111;
`ifdef HEALTH_BAR_EN
    if (bar_hit)
      pix_colour = 3'b110;
`endif
  end

  always_comb begin
    state_nx  = state;
    col_nx    = col;
    row_nx    = row;
    ux_nx     = ux_q;
    uy_nx     = uy_q;
    ex_nx     = ex_q;
    ey_nx     = ey_q;
`ifdef HEALTH_BAR_EN
    hp_nx     = hp_q;
`endif
    x_nx      = x;
    y_nx      = y;
    colour_nx = colour;
    plot_nx   = 1'b0;
    done_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = DRAW;
          ux_nx    = user_x;
          uy_nx    = user_y;
          ex_nx    = enemy_x;
          ey_nx    = enemy_y;
`ifdef HEALTH_BAR_EN
          hp_nx    = ship_health;
`endif
          col_nx   = '0;
          row_nx   = '0;
        end
      end
      DRAW: begin
        x_nx      = col;
        y_nx      = row;
        colour_nx = pix_colour;
        plot_nx   = 1'b1;
        if (col == 8'd159) begin
          col_nx = '0;
          if (row == 7'd119) begin
            row_nx   = '0;
            state_nx = DONE;
          end else begin
            row_nx = row + 7'd1;
          end
        end else begin
          col_nx = col + 8'd1;
        end
      end
      DONE: begin
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      col    <= '0;
      row    <= '0;
      ux_q   <= '0;
      uy_q   <= '0;
      ex_q   <= '0;
      ey_q   <= '0;
`ifdef HEALTH_BAR_EN
      hp_q   <= '0;
`endif
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      col    <= col_nx;
      row    <= row_nx;
      ux_q   <= ux_nx;
      uy_q   <= uy_nx;
      ex_q   <= ex_nx;
      ey_q   <= ey_nx;
`ifdef HEALTH_BAR_EN
      hp_q   <= hp_nx;
`endif
      x      <= x_nx;
      y      <= y_nx;
      colour <= colour_nx;
      plot   <= plot_nx;
      done   <= done_nx;
    end
  end

endmodule
